// File: rtl/fp16_to_fp8_pack.sv
// fp16_to_fp8_pack: converts FP16 to FP8 (E5M2 or E4M3, round-to-nearest-even) and packs byte pairs into 16-bit words.
// Optional macro FP8PACK_SATURATE_EN: finite overflow yields the signed max finite value instead of infinity.
module fp16_to_fp8_pack (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_fmt,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_odd,
  output logic [7:0]  ovf_cnt
);

  typedef enum logic [1:0] {EMPTY, HALF, FULL} state_t;

`ifdef FP8PACK_SATURATE_EN
  localparam logic [6:0] E5M2_OVF = 7'h7B;
  localparam logic [6:0] E4M3_OVF = 7'h77;
`else
  localparam logic [6:0] E5M2_OVF = 7'h7C;
  localparam logic [6:0] E4M3_OVF = 7'h78;
`endif

  state_t      state;
  state_t      state_nxt;
  logic        in_xfer;
  logic        out_xfer;
  logic [15:0] data_q;
  logic        odd_q;
  logic [7:0]  ovf_q;

  logic        sgn;
  logic [4:0]  exp_f;
  logic [9:0]  man;
  logic        e5_rne;
  logic [6:0]  e5_sum;
  logic [4:0]  e4_exp;
  logic        e4n_rne;
  logic [7:0]  e4n_sum;
  logic [4:0]  sub_shift;
  logic [18:0] sub_shv;
  logic        e4s_rne;
  logic [3:0]  e4s_sum;
  logic [7:0]  conv_byte;
  logic        conv_ovf;

  assign sgn   = in_data[15];
  assign exp_f = in_data[14:10];
  assign man   = in_data[9:0];

  // E5M2 shares the FP16 exponent, so rounding the mantissa to 2 bits covers normals and subnormals alike.
  assign e5_rne = man[7] & (man[6] | (|man[5:0]) | man[8]);
  assign e5_sum = {exp_f, man[9:8]} + {6'd0, e5_rne};

  // E4M3 normal path: rebias 15 -> 7; the 8-bit sum exposes overflow past exponent 14.
  assign e4_exp  = exp_f - 5'd8;
  assign e4n_rne = man[6] & (man[5] | (|man[4:0]) | man[7]);
  assign e4n_sum = {e4_exp, man[9:7]} + {7'd0, e4n_rne};

  // E4M3 subnormal path for FP16 exponents 1..8: align the significand to units of 2^-9.
  assign sub_shift = 5'd8 - exp_f;
  assign sub_shv   = {1'b1, man, 8'd0} >> sub_shift;
  assign e4s_rne   = sub_shv[15] & (sub_shv[14] | (|sub_shv[13:0]) | sub_shv[16]);
  assign e4s_sum   = {1'b0, sub_shv[18:16]} + {3'd0, e4s_rne};

  always_comb begin
    conv_byte = 8'h00;
    conv_ovf  = 1'b0;
    if (exp_f == 5'h1F) begin
      if (man != 10'd0) begin
        conv_byte = 8'h7F;
      end else begin
        conv_byte = {sgn, (in_fmt ? 7'h78 : 7'h7C)};
      end
    end else if (!in_fmt) begin
      if (e5_sum[6:2] == 5'h1F) begin
        conv_ovf  = 1'b1;
        conv_byte = {sgn, E5M2_OVF};
      end else begin
        conv_byte = {sgn, e5_sum};
      end
    end else if (exp_f == 5'd0) begin
      conv_byte = {sgn, 7'h00};
    end else if (exp_f < 5'd9) begin
      conv_byte = {sgn, 3'b000, e4s_sum};
    end else if (e4n_sum >= 8'd120) begin
      conv_ovf  = 1'b1;
      conv_byte = {sgn, E4M3_OVF};
    end else begin
      conv_byte = {sgn, e4n_sum[6:0]};
    end
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt = flush ? FULL : HALF;
        end
      end
      HALF: begin
        if (in_xfer || flush) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nxt = in_xfer ? HALF : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    in_ready  = (state != FULL) | out_ready;
  end

  // Word assembly: the first accepted byte always lands in [7:0]; a flushed half word is padded with 0x00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 16'h0000;
      odd_q  <= 1'b0;
      ovf_q  <= 8'h00;
    end else begin
      if (in_xfer && conv_ovf && (ovf_q != 8'hFF)) begin
        ovf_q <= ovf_q + 8'd1;
      end
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            data_q <= {8'h00, conv_byte};
            odd_q  <= flush;
          end
        end
        HALF: begin
          if (in_xfer) begin
            data_q[15:8] <= conv_byte;
            odd_q        <= 1'b0;
          end else if (flush) begin
            data_q[15:8] <= 8'h00;
            odd_q        <= 1'b1;
          end
        end
        FULL: begin
          if (out_xfer) begin
            data_q <= in_xfer ? {8'h00, conv_byte} : 16'h0000;
            odd_q  <= 1'b0;
          end
        end
        default: begin
          data_q <= 16'h0000;
          odd_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = data_q;
  assign out_odd  = odd_q;
  assign ovf_cnt  = ovf_q;

endmodule

// File: tb/tb_fp16_to_fp8_pack.sv
// tb_fp16_to_fp8_pack: scoreboard bench; expected FP8 bytes come from a value-based nearest-code search.
// Honours FP8PACK_SATURATE_EN the same way as the design build.
module tb_fp16_to_fp8_pack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        in_fmt;
  logic        flush;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_odd;
  logic [7:0]  ovf_cnt;

  int          err_cnt = 0;
  int          chk_cnt = 0;
  logic [16:0] exp_q[$];
  logic [7:0]  pend_byte;
  logic        pend_vld = 1'b0;
  int          ovf_model = 0;
  int          ready_mode = 0;

  fp16_to_fp8_pack dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_fmt(in_fmt), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_odd(out_odd), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Sink back-pressure: 0 = always ready, 1 = stalled, otherwise random.
  always begin
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, expv);
    end
  endtask

  function automatic real pow2(input int k);
    real r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real fp16Mag(input logic [15:0] h);
    int e = int'(h[14:10]);
    int m = int'(h[9:0]);
    if (e == 0) return m * pow2(-24);
    return (1024 + m) * pow2(e - 25);
  endfunction

  function automatic real fp8Mag(input logic [6:0] c, input logic fmt);
    int e;
    int m;
    if (!fmt) begin
      e = int'(c[6:2]);
      m = int'(c[1:0]);
      if (e == 0) return m * pow2(-16);
      return (4 + m) * pow2(e - 17);
    end
    e = int'(c[6:3]);
    m = int'(c[2:0]);
    if (e == 0) return m * pow2(-9);
    return (8 + m) * pow2(e - 10);
  endfunction

  // Returns {overflow, byte}: nearest representable magnitude, ties to the even code.
  function automatic logic [8:0] modelConv(input logic [15:0] h, input logic fmt);
    logic [6:0] maxc = fmt ? 7'h77 : 7'h7B;
    logic [6:0] infc = fmt ? 7'h78 : 7'h7C;
    logic [6:0] best = 7'h00;
    real v, mx, top, d, bd;
    if (h[14:10] == 5'h1F) begin
      if (h[9:0] != 10'd0) return {1'b0, 8'h7F};
      return {1'b0, h[15], infc};
    end
    v   = fp16Mag(h);
    mx  = fp8Mag(maxc, fmt);
    top = fmt ? 256.0 : 65536.0;
    if (v >= (mx + top) / 2.0) begin
`ifdef FP8PACK_SATURATE_EN
      return {1'b1, h[15], maxc};
`else
      return {1'b1, h[15], infc};
`endif
    end
    bd = v;
    for (int c = 1; c <= int'(maxc); c++) begin
      d = v - fp8Mag(7'(c), fmt);
      if (d < 0.0) d = -d;
      if (d < bd || (d == bd && (c % 2) == 0)) begin
        bd   = d;
        best = 7'(c);
      end
    end
    return {1'b0, h[15], best};
  endfunction

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic fmt, input logic fl);
    logic       acc = 1'b0;
    logic [8:0] r;
    int         n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_fmt   = fmt;
    flush    = fl;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    if (!acc) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      r = modelConv(d, fmt);
      if (r[8] && ovf_model < 255) ovf_model++;
      if (!pend_vld) begin
        if (fl) exp_q.push_back({1'b1, 8'h00, r[7:0]});
        else begin
          pend_byte = r[7:0];
          pend_vld  = 1'b1;
        end
      end else begin
        exp_q.push_back({1'b0, r[7:0], pend_byte});
        pend_vld = 1'b0;
      end
    end
  endtask

  task automatic sendFlush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    if (pend_vld) begin
      exp_q.push_back({1'b1, 8'h00, pend_byte});
      pend_vld = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        checkOutput("out_data", 32'(out_data), 32'(e[15:0]));
        checkOutput("out_odd", 32'(out_odd), 32'(e[16]));
      end
    end
  end

  initial begin
    logic [15:0] specials [8];
    specials = '{16'h7C00, 16'hFC00, 16'h7E01, 16'h0000, 16'h8000, 16'h03FF, 16'h7BFF, 16'h1401};
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 16'h0000;
    in_fmt   = 1'b0;
    flush    = 1'b0;
    #3;
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'h0000);
    checkOutput("rst_out_odd", 32'(out_odd), 32'd0);
    checkOutput("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);
    idleCycles(1);

    applyStimulus(16'h3C00, 1'b0, 1'b0);
    applyStimulus(16'hC000, 1'b0, 1'b0);
    checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
    checkOutput("pair_e5m2_data", 32'(out_data), 32'hC03C);
    applyStimulus(16'h3C00, 1'b1, 1'b0);
    applyStimulus(16'h5B80, 1'b1, 1'b0);
    applyStimulus(16'h1800, 1'b1, 1'b0);
    applyStimulus(16'h7E00, 1'b1, 1'b0);
    applyStimulus(16'h3C80, 1'b0, 1'b0);
    applyStimulus(16'h3D80, 1'b0, 1'b0);
    applyStimulus(16'h5BC0, 1'b1, 1'b0);
    applyStimulus(16'h5C00, 1'b1, 1'b0);
    idleCycles(2);
    checkOutput("ovf_cnt_two", 32'(ovf_cnt), 32'(ovf_model));

    applyStimulus(16'h1400, 1'b1, 1'b0);
    applyStimulus(16'h1C00, 1'b1, 1'b0);
    applyStimulus(16'h0300, 1'b0, 1'b0);
    applyStimulus(16'h0200, 1'b1, 1'b0);
    applyStimulus(16'h3C00, 1'b0, 1'b0);
    applyStimulus(16'h4000, 1'b0, 1'b1);
    idleCycles(2);
    sendFlush();
    #1;
    checkOutput("empty_flush_no_effect", 32'(out_valid), 32'd0);
    idleCycles(1);
    applyStimulus(16'hFC00, 1'b1, 1'b1);
    idleCycles(2);

    // Stalled sink: the flushed word must hold steady and block input.
    ready_mode = 1;
    idleCycles(1);
    applyStimulus(16'h3C00, 1'b0, 1'b0);
    sendFlush();
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_data", 32'(out_data), 32'h003C);
      checkOutput("stall_out_odd", 32'(out_odd), 32'd1);
    end
    @(posedge clk);
    #1;
    ready_mode = 0;
    idleCycles(3);

    applyStimulus(16'h4000, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    pend_vld  = 1'b0;
    ovf_model = 0;
    checkOutput("mid_rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    checkOutput("mid_rst_out_data", 32'(out_data), 32'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    idleCycles(1);
    applyStimulus(16'h3C00, 1'b0, 1'b0);
    applyStimulus(16'hC000, 1'b0, 1'b0);
    idleCycles(2);

    ready_mode = 2;
    for (int i = 0; i < 60; i++) begin
      logic [15:0] d;
      d = (i % 7 == 3) ? specials[i % 8] : 16'($urandom);
      if ($urandom_range(0, 7) == 0) sendFlush();
      else applyStimulus(d, 1'($urandom_range(0, 1)), 1'b0);
    end
    if (pend_vld) sendFlush();
    ready_mode = 0;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idleCycles(1);
    idleCycles(2);
    checkOutput("drain_left", 32'(exp_q.size()), 32'd0);
    checkOutput("ovf_cnt_final", 32'(ovf_cnt), 32'(ovf_model));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
